// File: rtl/argmax_if.sv
// Score vector in, top-2 argmax results out; master drives start/x, slave is the argmax block.
interface argmax_if #(
  parameter int WIDTH = 18,
  parameter int N     = 20,
  parameter int IDXW  = 5
);
  logic                    start;
  logic signed [WIDTH-1:0] x [0:N-1];
  logic [IDXW-1:0]         class_idx;
  logic signed [WIDTH-1:0] max_val;
  logic [IDXW-1:0]         second_idx;
  logic [WIDTH:0]          margin;
  logic                    busy;
  logic                    done;

  modport master (
    output start, x,
    input  class_idx, max_val, second_idx, margin, busy, done
  );

  modport slave (
    input  start, x,
    output class_idx, max_val, second_idx, margin, busy, done
  );
endinterface

// File: rtl/argmax_top2.sv
// Sequential top-2 argmax: snapshots N scores on a start rising edge, scans one per clock,
// then holds max, runner-up and their difference until the next trigger.
module argmax_top2 #(
  parameter int WIDTH = 18,
  parameter int N     = 20,
  parameter int IDXW  = 5
) (
  input logic      clk,
  input logic      reset,
  argmax_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

  localparam logic [IDXW-1:0] LastIdx = IDXW'(N - 1);

  state_e                  state_q, state_d;
  logic                    start_q;
  logic signed [WIDTH-1:0] snap_q [0:N-1];
  logic signed [WIDTH-1:0] snap_d [0:N-1];
  logic signed [WIDTH-1:0] best_q, best_d, sec_q, sec_d;
  logic [IDXW-1:0]         bidx_q, bidx_d, sidx_q, sidx_d;
  logic                    sec_valid_q, sec_valid_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic [IDXW-1:0]         class_q, class_d, second_q, second_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic [WIDTH:0]          margin_q, margin_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic                    trigger;
  logic signed [WIDTH-1:0] cur, best_n, sec_n;
  logic [IDXW-1:0]         bidx_n, sidx_n;
  logic [WIDTH:0]          margin_n;

  always_comb begin
    trigger = bus.start & ~start_q;
    cur     = snap_q[ptr_q];

    // Strict compares keep the lower index on ties in both slots.
    best_n = best_q;
    bidx_n = bidx_q;
    sec_n  = sec_q;
    sidx_n = sidx_q;
    if (cur > best_q) begin
      sec_n  = best_q;
      sidx_n = bidx_q;
      best_n = cur;
      bidx_n = ptr_q;
    end else if (!sec_valid_q || cur > sec_q) begin
      sec_n  = cur;
      sidx_n = ptr_q;
    end
    // Sign-extended to WIDTH+1 so max-min never wraps; result is always non-negative.
    margin_n = {best_n[WIDTH-1], best_n} - {sec_n[WIDTH-1], sec_n};

    state_d     = state_q;
    snap_d      = snap_q;
    best_d      = best_q;
    bidx_d      = bidx_q;
    sec_d       = sec_q;
    sidx_d      = sidx_q;
    sec_valid_d = sec_valid_q;
    ptr_d       = ptr_q;
    class_d     = class_q;
    second_d    = second_q;
    max_d       = max_q;
    margin_d    = margin_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      StIdle, StHold: begin
        if (trigger) begin
          snap_d      = bus.x;
          best_d      = bus.x[0];
          bidx_d      = '0;
          sec_valid_d = 1'b0;
          ptr_d       = IDXW'(1);
          state_d     = StScan;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end
      StScan: begin
        best_d      = best_n;
        bidx_d      = bidx_n;
        sec_d       = sec_n;
        sidx_d      = sidx_n;
        sec_valid_d = 1'b1;
        ptr_d       = ptr_q + IDXW'(1);
        if (ptr_q == LastIdx) begin
          class_d  = bidx_n;
          max_d    = best_n;
          second_d = sidx_n;
          margin_d = margin_n;
          state_d  = StHold;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      snap_q      <= '{default: '0};
      best_q      <= '0;
      bidx_q      <= '0;
      sec_q       <= '0;
      sidx_q      <= '0;
      sec_valid_q <= 1'b0;
      ptr_q       <= '0;
      class_q     <= '0;
      second_q    <= '0;
      max_q       <= '0;
      margin_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.start;
      snap_q      <= snap_d;
      best_q      <= best_d;
      bidx_q      <= bidx_d;
      sec_q       <= sec_d;
      sidx_q      <= sidx_d;
      sec_valid_q <= sec_valid_d;
      ptr_q       <= ptr_d;
      class_q     <= class_d;
      second_q    <= second_d;
      max_q       <= max_d;
      margin_q    <= margin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.class_idx  = class_q;
  assign bus.max_val    = max_q;
  assign bus.second_idx = second_q;
  assign bus.margin     = margin_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_argmax_top2.sv
// Directed bench for argmax_top2 at default parameters with hand-computed expectations.
module tb_argmax_top2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  argmax_if #(.WIDTH(18), .N(20), .IDXW(5)) bus ();

  argmax_top2 #(.WIDTH(18), .N(20), .IDXW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int v1 [20] = '{-24130, -48195, 50129, 34711, 50462, 54944, -11999, 32637, 60452, 10086,
                  -46241, 35623, 66240, 34456, -44209, 54243, 45059, 55347, 66980, 11840};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 20; i++) bus.x[i] = 18'(v);
  endtask

  task automatic load_vec(input int v [20]);
    for (int i = 0; i < 20; i++) bus.x[i] = 18'(v[i]);
  endtask

  // Raises start, checks the trigger edge, then counts edges until done.
  task automatic run_scan(input string tag, input int old_class);
    int n;
    bit seen;
    bus.start = 1'b1;
    tick();
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_done_low"}, bus.done, 0);
    chk({tag, "_old_class"}, bus.class_idx, old_class);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_latency"}, n, 19);
    chk({tag, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    int  n;
    bit  seen;
    reset     = 1'b0;
    bus.start = 1'b0;
    set_all(0);
    repeat (3) tick();
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_class", bus.class_idx, 0);
    chk("rst_max", bus.max_val, 0);
    chk("rst_second", bus.second_idx, 0);
    chk("rst_margin", bus.margin, 0);
    reset = 1'b1;
    tick();

    // Basic scan
    load_vec(v1);
    run_scan("basic", 0);
    chk("basic_class", bus.class_idx, 18);
    chk("basic_max", bus.max_val, 66980);
    chk("basic_second", bus.second_idx, 12);
    chk("basic_margin", bus.margin, 740);

    // Ties, retriggered from HOLD: old class stays visible during the scan
    bus.start = 1'b0;
    tick();
    set_all(1000);
    run_scan("ties", 18);
    chk("ties_class", bus.class_idx, 0);
    chk("ties_max", bus.max_val, 1000);
    chk("ties_second", bus.second_idx, 1);
    chk("ties_margin", bus.margin, 0);

    // Extremes
    bus.start = 1'b0;
    tick();
    set_all(-131072);
    bus.x[3] = 18'(131071);
    run_scan("ext", 0);
    chk("ext_class", bus.class_idx, 3);
    chk("ext_max", bus.max_val, 131071);
    chk("ext_second", bus.second_idx, 0);
    chk("ext_margin", bus.margin, 262143);

    // Snapshot isolation and ignored trigger during SCAN
    bus.start = 1'b0;
    tick();
    load_vec(v1);
    bus.start = 1'b1;
    tick();
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (n == 5) begin
        bus.start = 1'b0;
        set_all(5000);
      end else if (n == 6) bus.start = 1'b1;
    end
    chk("snap_latency", n, 19);
    chk("snap_class", bus.class_idx, 18);
    chk("snap_max", bus.max_val, 66980);
    repeat (25) tick();
    chk("snap_no_rescan_done", bus.done, 1);
    chk("snap_no_rescan_busy", bus.busy, 0);
    chk("snap_margin", bus.margin, 740);

    // Reset mid-scan, then restart
    bus.start = 1'b0;
    tick();
    set_all(-131072);
    bus.x[3] = 18'(131071);
    bus.start = 1'b1;
    tick();
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_class", bus.class_idx, 0);
    chk("arst_max", bus.max_val, 0);
    chk("arst_margin", bus.margin, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_busy", bus.busy, 0);
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (bus.done !== 1'b0) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);
    run_scan("restart", 0);
    chk("restart_class", bus.class_idx, 3);
    chk("restart_margin", bus.margin, 262143);

    // Held start: no retrigger until start falls and rises again
    repeat (25) tick();
    chk("held_done", bus.done, 1);
    chk("held_busy", bus.busy, 0);
    load_vec(v1);
    bus.start = 1'b0;
    tick();
    run_scan("held", 3);
    chk("held_class", bus.class_idx, 18);
    chk("held_second", bus.second_idx, 12);
    repeat (25) tick();
    chk("held_once_done", bus.done, 1);
    chk("held_once_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/argmax_top2.md
ARGMAX_TOP2 -- requirements
Module: argmax_top2

Interface
REQ-001 SHALL have parameter WIDTH, default 18, giving the signed score width (Q2.15 from the dense layer).
REQ-002 SHALL have parameter N, default 20, giving the number of scores; legal range 2..32.
REQ-003 SHALL have parameter IDXW, default 5, giving the index width; IDXW SHALL satisfy 2^IDXW >= N.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: connected to the upstream layer's done output, which is level-held.
REQ-007 SHALL have port x, input, an array [0:N-1] of signed WIDTH-bit values: the upstream layer's y outputs.
REQ-008 SHALL have port class_idx, output, IDXW bits: index of the maximum score.
REQ-009 SHALL have port max_val, output, signed WIDTH bits: the maximum score.
REQ-010 SHALL have port second_idx, output, IDXW bits: index of the runner-up score.
REQ-011 SHALL have port margin, output, unsigned WIDTH+1 bits: max_val minus the runner-up value.
REQ-012 SHALL have port busy, output, 1 bit: high while scanning.
REQ-013 SHALL have port done, output, 1 bit: high while the results are valid.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, SCAN and HOLD.
REQ-015 SHALL register start into start_q and define a trigger as start=1 while start_q=0, sampled at a rising clk edge.
REQ-016 SHALL act on a trigger in IDLE or HOLD as follows, all at the same edge:
- snapshot all N elements of x into internal registers;
- set best=x[0] and bidx=0;
- mark second as invalid;
- set the pointer i=1;
- enter SCAN, with busy=1 and done=0.
REQ-017 SHALL, in SCAN, process one snapshot element per edge for i = 1..N-1, and SHALL not sample x during SCAN.
REQ-018 SHALL, when snap[i] > best (strict signed compare), move best and bidx into second and sidx, then load snap[i] and i into best and bidx.
REQ-019 SHALL, when the REQ-018 condition is false and either second is invalid or snap[i] > second, load snap[i] and i into second and sidx.
REQ-020 SHALL, on ties, keep the lower index in both the best and second positions.
REQ-021 SHALL always have second valid after processing i=1, since N >= 2.
REQ-022 SHALL, at the edge processing i=N-1:
- compute the outputs from the updated values;
- register class_idx, max_val, second_idx and margin=best-second, computed at WIDTH+1 bits so it never wraps;
- enter HOLD with done=1 and busy=0.
REQ-023 SHALL assert done exactly N-1 edges after the trigger edge (19 cycles at the defaults).
REQ-024 SHALL hold its outputs and done stable in HOLD until the next trigger or reset.
REQ-025 SHALL deassert done at the trigger edge when a trigger arrives in HOLD, leaving the old values on the result outputs until the new scan completes.
REQ-026 SHALL ignore a trigger arriving during SCAN, with no restart and no snapshot.
REQ-027 SHALL not retrigger while start is held high; a new scan requires start to fall and then rise again.
REQ-028 SHALL treat start already high when reset is released as a trigger on the first edge, because start_q resets to 0.

Reset
REQ-029 SHALL, while reset=0, asynchronously force:
- state to IDLE;
- done=0 and busy=0;
- class_idx, second_idx, max_val and margin to 0;
- start_q, the pointer and all snapshot, best and second registers to 0.
REQ-030 SHALL abort a scan in progress when reset is asserted mid-SCAN, and SHALL produce no done pulse after release until a new trigger.

Verification
REQ-031 SHALL cover a basic argmax scan:
- stimulus: x = {-24130,-48195,50129,34711,50462,54944,-11999,32637,60452,10086,-46241,35623,66240,34456,-44209,54243,45059,55347,66980,11840}, start raised;
- response: after 19 edges done=1, class_idx=18, max_val=66980, second_idx=12, margin=740.
REQ-032 SHALL cover ties:
- stimulus: all x=1000;
- response: class_idx=0, second_idx=1, margin=0.
REQ-033 SHALL cover extreme values:
- stimulus: x[3]=131071, x[7]=-131072, all others -131072;
- response: class_idx=3, second_idx=0, margin=262143 with no overflow.
REQ-034 SHALL cover snapshot isolation and a busy-period trigger:
- stimulus: x changed and start toggled at cycle 5 of SCAN;
- response: the result reflects the values captured at the trigger, done arrives at the original edge 19, and no second scan follows.
REQ-035 SHALL cover reset and restart:
- stimulus: reset pulsed low at cycle 10 of SCAN, then a new trigger issued;
- response: outputs are 0 immediately, and done rises exactly 19 edges after the new trigger.
REQ-036 SHALL cover a held start:
- stimulus: start held high through HOLD, then dropped and re-raised;
- response: exactly one rescan, with done low from the trigger edge until 19 edges later.
